telemetry_packetizer: RTL

Downstream telemetry stage for the spacecraft camera/sensor top level. It periodically snapshots the 1-bit temperature, pressure and current sensor levels, the 16-bit pos_x/pos_y/pos_z position words and an overrun flag. Each snapshot is serialised into a fixed 11-byte frame on a byte-wide valid/ready stream. A downlink UART or link serialiser consumes that stream.

---
 rtl/telemetry_packetizer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/telemetry_packetizer.sv
// telemetry_packetizer
// Periodically snapshots sensor levels, position words and an overrun flag,
// then streams an 11-byte frame on a byte-wide valid/ready interface:
//   SYNC_HI, SYNC_LO, seq, flags, x_hi, x_lo, y_hi, y_lo, z_hi, z_lo, check
// Build option: define TLM_CRC8_EN to make the check byte a CRC-8
// (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) over
// bytes 2..9; otherwise it is the 8-bit modular sum of bytes 2..9.
module telemetry_packetizer #(
  parameter int unsigned PERIOD  = 1000,
  parameter logic [7:0]  SYNC_HI = 8'hEB,
  parameter logic [7:0]  SYNC_LO = 8'h90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        temp_sensor,
  input  logic        press_sensor,
  input  logic        current_sensor,
  input  logic [15:0] pos_x,
  input  logic [15:0] pos_y,
  input  logic [15:0] pos_z,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam int unsigned    CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
  localparam logic [3:0]     LAST_IDX = 4'd10;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  // One check-byte accumulation step for a single frame byte.
  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef TLM_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
`else
    return acc + b;
`endif
  endfunction

  // Frame byte for indices 0..9; the check byte is handled separately.
  function automatic logic [7:0] frame_byte(
    input logic [3:0]  idx,
    input logic [7:0]  seq,
    input logic [7:0]  flags,
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z
  );
    logic [7:0] b;
    case (idx)
      4'd0:    b = SYNC_HI;
      4'd1:    b = SYNC_LO;
      4'd2:    b = seq;
      4'd3:    b = flags;
      4'd4:    b = x[15:8];
      4'd5:    b = x[7:0];
      4'd6:    b = y[15:8];
      4'd7:    b = y[7:0];
      4'd8:    b = z[15:8];
      4'd9:    b = z[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       seq_q, seq_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [7:0]       snap_flags_q, snap_flags_d;
  logic [15:0]      snap_x_q, snap_x_d;
  logic [15:0]      snap_y_q, snap_y_d;
  logic [15:0]      snap_z_q, snap_z_d;

  logic             trigger;
  logic             accept;
  logic [3:0]       nxt_idx;
  logic [7:0]       chk_upd;

  // Free-running period counter; held at zero while disabled.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cnt_d   = '0;
    trigger = 1'b0;
    if (enable) begin
      trigger = (cnt_q == CNT_MAX);
      cnt_d   = trigger ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Frame FSM: snapshot on trigger, present one byte per accepted transfer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seq_d        = seq_q;
    ovf_d        = ovf_q;
    ovr_d        = ovr_q;
    chk_d        = chk_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    snap_flags_d = snap_flags_q;
    snap_x_d     = snap_x_q;
    snap_y_d     = snap_y_q;
    snap_z_d     = snap_z_q;
    accept       = m_valid_q && m_ready;
    nxt_idx      = idx_q + 4'd1;
    chk_upd      = (idx_q >= 4'd2 && idx_q <= 4'd9) ? chk_step(chk_q, m_data_q) : chk_q;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          snap_flags_d = {ovf_q, 4'b0000, current_sensor, press_sensor, temp_sensor};
          snap_x_d     = pos_x;
          snap_y_d     = pos_y;
          snap_z_d     = pos_z;
          ovf_d        = 1'b0;
          idx_d        = 4'd0;
          chk_d        = 8'h00;
          m_data_d     = SYNC_HI;
          m_valid_d    = 1'b1;
          m_last_d     = 1'b0;
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        // A trigger while busy, including on the final-byte edge, is dropped.
        if (trigger) begin
          ovf_d = 1'b1;
          if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
        end
        if (accept) begin
          chk_d = chk_upd;
          if (idx_q == LAST_IDX) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            seq_d     = seq_q + 8'd1;
            state_d   = S_IDLE;
          end else begin
            idx_d    = nxt_idx;
            m_last_d = (nxt_idx == LAST_IDX);
            m_data_d = (nxt_idx == LAST_IDX) ? chk_upd
                     : frame_byte(nxt_idx, seq_q, snap_flags_q, snap_x_q, snap_y_q, snap_z_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= 4'd0;
      seq_q     <= 8'h00;
      ovf_q     <= 1'b0;
      ovr_q     <= 8'h00;
      chk_q     <= 8'h00;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      ovf_q     <= ovf_d;
      ovr_q     <= ovr_d;
      chk_q     <= chk_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  // Snapshot payload registers.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; they are always loaded before being presented.
    snap_flags_q <= snap_flags_d;
    snap_x_q     <= snap_x_d;
    snap_y_q     <= snap_y_d;
    snap_z_q     <= snap_z_d;
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign busy        = (state_q == S_SEND);
  assign overrun_cnt = ovr_q;

endmodule
